// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment reader: segment bit positions,
// the digit glyphs on {g,f,e,d,c,b,a}, the blank glyph and the filter states.
package seg7_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [6:0] PAT_0     = 7'h3F;
   localparam logic [6:0] PAT_1     = 7'h06;
   localparam logic [6:0] PAT_2     = 7'h5B;
   localparam logic [6:0] PAT_3     = 7'h4F;
   localparam logic [6:0] PAT_4     = 7'h66;
   localparam logic [6:0] PAT_5     = 7'h6D;
   localparam logic [6:0] PAT_6     = 7'h7D;
   localparam logic [6:0] PAT_7     = 7'h07;
   localparam logic [6:0] PAT_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FILTER   = 2'd1,
      ST_REPORTED = 2'd2
   } filt_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational glyph decoder: 7-bit segment pattern {g..a} to {err, digit}.
// Blank decodes as digit 0 without error; callers decide whether blank matters.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       err,
   output logic [2:0] digit
);

   // Table lookup; anything that is not a known glyph or blank is an error.
   always_comb begin
      err   = 1'b0;
      digit = 3'd0;
      case (pattern)
         PAT_0:     digit = 3'd0;
         PAT_1:     digit = 3'd1;
         PAT_2:     digit = 3'd2;
         PAT_3:     digit = 3'd3;
         PAT_4:     digit = 3'd4;
         PAT_5:     digit = 3'd5;
         PAT_6:     digit = 3'd6;
         PAT_7:     digit = 3'd7;
         PAT_BLANK: digit = 3'd0;
         default:   err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_digit_reader.sv
// Seven-segment digit reader: debounces the segment bus, decodes each newly
// stable glyph once, and hands results out on a valid/ready stream backed by
// a holding register plus one pending slot.
// Optional feature macro: SEG7_READER_ERRCNT_EN enables the saturating
// illegal-pattern counter on err_count (tied to zero otherwise).
module seg7_digit_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] digit_out,
   output logic       err_out,
   output logic       overrun,
   output logic [7:0] err_count
);

   generate
      if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
         $error("seg7_digit_reader: STABLE_CYCLES must be within 1..255");
      end
   endgenerate

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   // The decimal point never takes part in decoding or comparison.
   logic unused_dp;
   assign unused_dp = seg_in[SEG_DP];

   logic [6:0]  seg_q, seg_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [6:0]  last_q, last_d;
   filt_state_e state_q, state_d;

   logic        hold_vld_q, hold_vld_d;
   logic [2:0]  hold_digit_q, hold_digit_d;
   logic        hold_err_q, hold_err_d;
   logic        pend_vld_q, pend_vld_d;
   logic [2:0]  pend_digit_q, pend_digit_d;
   logic        pend_err_q, pend_err_d;
   logic        overrun_q, overrun_d;

   logic        changed;
   logic        stable;
   logic        blank;
   logic        accept;
   logic        xfer;
   logic        dec_err;
   logic [2:0]  dec_digit;

   // Stability filter: reload on any change, otherwise count up to the limit.
   always_comb begin
      seg_d   = seg_q;
      cnt_d   = cnt_q;
      changed = (seg_in[SEG_G:SEG_A] != seg_q);
      if (changed) begin
         seg_d = seg_in[SEG_G:SEG_A];
         cnt_d = 8'd1;
      end else if (cnt_q != STABLE_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
      stable = (cnt_d == STABLE_MAX);
      blank  = (seg_d == PAT_BLANK);
   end

   // Decode the pattern the filter is about to hold, so acceptance and
   // decode land on the same edge.
   seg7_pattern_decode u_decode (
      .pattern (seg_d),
      .err     (dec_err),
      .digit   (dec_digit)
   );

   // Filter FSM: a stable non-blank glyph different from the last one reported
   // is accepted once; a stable blank re-arms reporting of any glyph.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      accept  = 1'b0;
      if (changed) begin
         state_d = ST_FILTER;
      end
      if (stable) begin
         if (blank) begin
            state_d = ST_IDLE;
            last_d  = PAT_BLANK;
         end else begin
            if ((changed || state_q != ST_REPORTED) && (seg_d != last_q)) begin
               accept = 1'b1;
               last_d = seg_d;
            end
            state_d = ST_REPORTED;
         end
      end
   end

   // Output buffer: the holding register drives the port, the pending slot
   // absorbs one result while the consumer stalls; a second stalled result
   // replaces the pending one and raises the sticky overrun flag.
   always_comb begin
      hold_vld_d   = hold_vld_q;
      hold_digit_d = hold_digit_q;
      hold_err_d   = hold_err_q;
      pend_vld_d   = pend_vld_q;
      pend_digit_d = pend_digit_q;
      pend_err_d   = pend_err_q;
      overrun_d    = overrun_q;
      xfer         = hold_vld_q && out_ready;
      if (xfer) begin
         if (pend_vld_q) begin
            hold_vld_d   = 1'b1;
            hold_digit_d = pend_digit_q;
            hold_err_d   = pend_err_q;
            if (accept) begin
               pend_vld_d   = 1'b1;
               pend_digit_d = dec_digit;
               pend_err_d   = dec_err;
            end else begin
               pend_vld_d = 1'b0;
            end
         end else if (accept) begin
            hold_vld_d   = 1'b1;
            hold_digit_d = dec_digit;
            hold_err_d   = dec_err;
         end else begin
            hold_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!hold_vld_q) begin
            hold_vld_d   = 1'b1;
            hold_digit_d = dec_digit;
            hold_err_d   = dec_err;
         end else begin
            if (pend_vld_q) begin
               overrun_d = 1'b1;
            end
            pend_vld_d   = 1'b1;
            pend_digit_d = dec_digit;
            pend_err_d   = dec_err;
         end
      end
   end

   // State registers; reset discards filter progress and any buffered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q        <= PAT_BLANK;
         cnt_q        <= 8'd0;
         last_q       <= PAT_BLANK;
         state_q      <= ST_IDLE;
         hold_vld_q   <= 1'b0;
         hold_digit_q <= 3'd0;
         hold_err_q   <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_digit_q <= 3'd0;
         pend_err_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         state_q      <= state_d;
         hold_vld_q   <= hold_vld_d;
         hold_digit_q <= hold_digit_d;
         hold_err_q   <= hold_err_d;
         pend_vld_q   <= pend_vld_d;
         pend_digit_q <= pend_digit_d;
         pend_err_q   <= pend_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign out_valid = hold_vld_q;
   assign digit_out = hold_digit_q;
   assign err_out   = hold_err_q;
   assign overrun   = overrun_q;

`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Count illegal glyphs at acceptance time, saturating at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (accept && dec_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= 8'h00;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_digit_reader.sv
// Directed bench for seg7_digit_reader with STABLE_CYCLES = 4.
module tb_seg7_digit_reader;

`ifdef SEG7_READER_ERRCNT_EN
   localparam bit ERRCNT_ON = 1'b1;
`else
   localparam bit ERRCNT_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] seg_in;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] digit_out;
   logic       err_out;
   logic       overrun;
   logic [7:0] err_count;

   int checks;
   int errors;
   logic [3:0] res_q[$];

   seg7_digit_reader #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .digit_out (digit_out),
      .err_out   (err_out),
      .overrun   (overrun),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [7:0] p, input int n);
      seg_in = p;
      repeat (n) tick();
   endtask

   // Drive a pattern for n cycles and record every {err,digit} seen valid.
   task automatic collect(input logic [7:0] p, input int n);
      seg_in = p;
      repeat (n) begin
         tick();
         if (out_valid) res_q.push_back({err_out, digit_out});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; seg_in = 8'h00; out_ready = 1'b0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (digit_out !== 3'd0) begin errors++; $display("FAIL reset_digit: got %0d expected 0", digit_out); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_out); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
      checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %0h expected 0", err_count); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      seg_in = 8'h5B;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_%0d: got valid %0b expected 0", k, out_valid); end
      end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", out_valid); end
      checks++; if (digit_out !== 3'd2) begin errors++; $display("FAIL single_digit: got %0d expected 2", digit_out); end
      checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL single_err: got %0b expected 0", err_out); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b expected 0", out_valid); end
      res_q.delete();
      collect(8'h5B, 8);
      checks++; if (res_q.size() != 0) begin errors++; $display("FAIL single_repeat: got %0d results expected 0", res_q.size()); end
   endtask

   task automatic test_glitch();
      out_ready = 1'b1;
      hold(8'h00, 6);
      res_q.delete();
      collect(8'h06, 2);
      collect(8'h4F, 10);
      checks++; if (res_q.size() != 1) begin errors++; $display("FAIL glitch_count: got %0d expected 1", res_q.size()); end
      else begin
         checks++; if (res_q[0] !== 4'h3) begin errors++; $display("FAIL glitch_value: got %0h expected 3", res_q[0]); end
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      res_q.delete();
      collect(8'h00, 6);
      collect(8'h49, 8);
      checks++; if (res_q.size() != 1) begin errors++; $display("FAIL illegal_count: got %0d expected 1", res_q.size()); end
      else begin
         checks++; if (res_q[0] !== 4'h8) begin errors++; $display("FAIL illegal_value: got %0h expected 8 (err=1,digit=0)", res_q[0]); end
      end
      checks++; if (err_count !== (ERRCNT_ON ? 8'd1 : 8'd0)) begin errors++; $display("FAIL illegal_errcnt1: got %0d expected %0d", err_count, ERRCNT_ON ? 1 : 0); end
      res_q.delete();
      collect(8'h00, 6);
      collect(8'h49, 8);
      checks++; if (res_q.size() != 1) begin errors++; $display("FAIL illegal_again_count: got %0d expected 1", res_q.size()); end
      checks++; if (err_count !== (ERRCNT_ON ? 8'd2 : 8'd0)) begin errors++; $display("FAIL illegal_errcnt2: got %0d expected %0d", err_count, ERRCNT_ON ? 2 : 0); end
   endtask

   task automatic test_buffering();
      out_ready = 1'b0;
      hold(8'h00, 6);
      hold(8'h07, 5);
      hold(8'h06, 5);
      hold(8'h6D, 5);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL buf_overrun: got %0b expected 1", overrun); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (out_valid !== 1'b1 || digit_out !== 3'd7) begin errors++; $display("FAIL buf_stall_%0d: got valid %0b digit %0d expected valid 1 digit 7", k, out_valid, digit_out); end
         tick();
      end
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1 || digit_out !== 3'd7) begin errors++; $display("FAIL buf_first: got valid %0b digit %0d expected valid 1 digit 7", out_valid, digit_out); end
      tick();
      checks++; if (out_valid !== 1'b1 || digit_out !== 3'd5) begin errors++; $display("FAIL buf_second: got valid %0b digit %0d expected valid 1 digit 5", out_valid, digit_out); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL buf_drained: got valid %0b expected 0", out_valid); end
   endtask

   task automatic test_blank_repeat();
      out_ready = 1'b1;
      res_q.delete();
      collect(8'h00, 6);
      collect(8'h66, 6);
      collect(8'h00, 4);
      collect(8'h66, 6);
      checks++; if (res_q.size() != 2) begin errors++; $display("FAIL blank_rearm_count: got %0d expected 2", res_q.size()); end
      else begin
         checks++; if (res_q[0] !== 4'h4 || res_q[1] !== 4'h4) begin errors++; $display("FAIL blank_rearm_value: got %0h,%0h expected 4,4", res_q[0], res_q[1]); end
      end
      res_q.delete();
      collect(8'h00, 6);
      collect(8'h66, 6);
      collect(8'h80, 2);
      collect(8'h66, 6);
      checks++; if (res_q.size() != 1) begin errors++; $display("FAIL dp_only_count: got %0d expected 1", res_q.size()); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      hold(8'h00, 6);
      hold(8'h07, 5);
      hold(8'h06, 5);
      hold(8'h6D, 5);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %0b expected 1", out_valid); end
      rst = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %0b expected 0", overrun); end
      checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL rstmid_errcnt: got %0h expected 0", err_count); end
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_%0d: got valid %0b expected 0", k, out_valid); end
      end
      tick();
      checks++; if (out_valid !== 1'b1 || digit_out !== 3'd5) begin errors++; $display("FAIL rstmid_rereport: got valid %0b digit %0d expected valid 1 digit 5", out_valid, digit_out); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      seg_in = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_illegal();
      test_buffering();
      test_blank_repeat();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
